// File: rtl/queue_wait_controller.sv
// Customer-queue controller: debounced arrival/departure buttons drive an occupancy counter,
// and a serial restoring divider estimates ceil(SERVICE*count/tellers) for a 2-digit display.
module queue_wait_controller #(
  parameter int unsigned DEPTH           = 15,
  parameter int unsigned N_TELLER        = 3,
  parameter int unsigned SERVICE         = 3,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned WAIT_W          = 8,
  localparam int unsigned CNT_W          = $clog2(DEPTH + 1),
  localparam int unsigned TW_W           = $clog2(N_TELLER + 1)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                up_n,
  input  logic                down_n,
  input  logic [N_TELLER-1:0] sw,
  output logic [CNT_W-1:0]    count,
  output logic [TW_W-1:0]     tellers,
  output logic [WAIT_W-1:0]   wait_time,
  output logic [3:0]          wait_tens,
  output logic [3:0]          wait_ones,
  output logic                wait_valid,
  output logic                busy,
  output logic                no_teller,
  output logic                led_empty,
  output logic                led_full,
  output logic                err
);

  localparam int unsigned DBC_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned PROD_W = $clog2(SERVICE * DEPTH + N_TELLER + 1);
  localparam int unsigned DW     = PROD_W + WAIT_W;
  localparam int unsigned BIT_W  = $clog2(WAIT_W + 1);

  typedef enum logic [1:0] {StIdle, StLoad, StDivide, StDone} state_e;

  // ---------------------------------------------------------------------------
  // Button synchronisers and debouncers (bit 0 = up, bit 1 = down)
  // ---------------------------------------------------------------------------
  logic [1:0]       btn_meta_q, btn_sync_q;
  logic [1:0]       btn_db_q, btn_db_d;
  logic [DBC_W-1:0] btn_cnt_q [2];
  logic [DBC_W-1:0] btn_cnt_d [2];
  logic [1:0]       press;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      btn_meta_q <= '1;
      btn_sync_q <= '1;
      btn_db_q   <= '1;
      btn_cnt_q  <= '{default: '0};
    end else begin
      btn_meta_q <= {down_n, up_n};
      btn_sync_q <= btn_meta_q;
      btn_db_q   <= btn_db_d;
      btn_cnt_q  <= btn_cnt_d;
    end
  end

  // The counter only runs while the sampled level disagrees with the accepted one,
  // so any bounce back to the accepted level restarts it from zero.
  always_comb begin
    btn_db_d     = btn_db_q;
    press        = '0;
    btn_cnt_d[0] = '0;
    btn_cnt_d[1] = '0;
    for (int i = 0; i < 2; i++) begin
      if (btn_sync_q[i] != btn_db_q[i]) begin
        if (btn_cnt_q[i] == DBC_W'(DEBOUNCE_CYCLES - 1)) begin
          btn_db_d[i] = btn_sync_q[i];
          press[i]    = ~btn_sync_q[i];
        end else begin
          btn_cnt_d[i] = btn_cnt_q[i] + DBC_W'(1);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Occupancy counter
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] count_q, count_d;
  logic             err_q, err_d;

  always_comb begin
    count_d = count_q;
    err_d   = 1'b0;
    if (press[0] && !press[1]) begin
      if (count_q == CNT_W'(DEPTH)) begin
        err_d = 1'b1;
      end else begin
        count_d = count_q + CNT_W'(1);
      end
    end else if (press[1] && !press[0]) begin
      if (count_q == '0) begin
        err_d = 1'b1;
      end else begin
        count_d = count_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Teller switches: synchronise, then registered popcount
  // ---------------------------------------------------------------------------
  logic [N_TELLER-1:0] sw_meta_q, sw_sync_q;
  logic [TW_W-1:0]     tellers_q, tellers_d;

  always_comb begin
    tellers_d = '0;
    for (int i = 0; i < int'(N_TELLER); i++) begin
      tellers_d = tellers_d + TW_W'(sw_sync_q[i]);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sw_meta_q <= '0;
      sw_sync_q <= '0;
      tellers_q <= '0;
    end else begin
      sw_meta_q <= sw;
      sw_sync_q <= sw_meta_q;
      tellers_q <= tellers_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Wait-time divider FSM
  // ---------------------------------------------------------------------------
  state_e            state_q, state_d;
  logic [CNT_W-1:0]  op_cnt_q, op_cnt_d;
  logic [TW_W-1:0]   op_tel_q, op_tel_d;
  logic [WAIT_W-1:0] div_q, div_d;
  logic [WAIT_W-1:0] quo_q, quo_d;
  logic [TW_W-1:0]   rem_q, rem_d;
  logic              ovf_q, ovf_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              no_teller_q, no_teller_d;

  logic              ops_differ;
  logic [DW-1:0]     dividend;
  logic [TW_W:0]     trial;
  logic              trial_ge;

  assign ops_differ = {count_q, tellers_q} != {op_cnt_q, op_tel_q};
  // Adding (tellers-1) before dividing turns the floor division into a ceiling.
  assign dividend   = DW'(SERVICE) * DW'(op_cnt_q) + DW'(op_tel_q) - DW'(1);
  assign trial      = {rem_q, div_q[WAIT_W-1]};
  assign trial_ge   = trial >= {1'b0, op_tel_q};

  always_comb begin
    state_d     = state_q;
    op_cnt_d    = op_cnt_q;
    op_tel_d    = op_tel_q;
    div_d       = div_q;
    quo_d       = quo_q;
    rem_d       = rem_q;
    ovf_d       = ovf_q;
    bit_d       = bit_q;
    wait_d      = wait_q;
    no_teller_d = no_teller_q;
    unique case (state_q)
      StIdle: begin
        if (ops_differ) begin
          state_d  = StLoad;
          op_cnt_d = count_q;
          op_tel_d = tellers_q;
        end
      end
      StLoad: begin
        if (op_tel_q == '0) begin
          state_d     = StDone;
          wait_d      = '1;
          no_teller_d = 1'b1;
        end else if (op_cnt_q == '0) begin
          state_d     = StDone;
          wait_d      = '0;
          no_teller_d = 1'b0;
        end else begin
          // Bits above WAIT_W seed the remainder; if they already reach the divisor the
          // quotient cannot fit and the result saturates.
          state_d = StDivide;
          ovf_d   = (dividend >> WAIT_W) >= DW'(op_tel_q);
          rem_d   = TW_W'(dividend >> WAIT_W);
          div_d   = dividend[WAIT_W-1:0];
          quo_d   = '0;
          bit_d   = '0;
        end
      end
      StDivide: begin
        div_d = div_q << 1;
        quo_d = {quo_q[WAIT_W-2:0], trial_ge};
        rem_d = trial_ge ? TW_W'(trial - {1'b0, op_tel_q}) : TW_W'(trial);
        bit_d = bit_q + BIT_W'(1);
        if (bit_q == BIT_W'(WAIT_W - 1)) begin
          state_d     = StDone;
          wait_d      = ovf_q ? '1 : {quo_q[WAIT_W-2:0], trial_ge};
          no_teller_d = 1'b0;
        end
      end
      StDone: begin
        if (ops_differ) begin
          state_d  = StLoad;
          op_cnt_d = count_q;
          op_tel_d = tellers_q;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      op_cnt_q    <= '0;
      op_tel_q    <= '0;
      div_q       <= '0;
      quo_q       <= '0;
      rem_q       <= '0;
      ovf_q       <= 1'b0;
      bit_q       <= '0;
      wait_q      <= '0;
      no_teller_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_cnt_q    <= op_cnt_d;
      op_tel_q    <= op_tel_d;
      div_q       <= div_d;
      quo_q       <= quo_d;
      rem_q       <= rem_d;
      ovf_q       <= ovf_d;
      bit_q       <= bit_d;
      wait_q      <= wait_d;
      no_teller_q <= no_teller_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    if (32'(wait_q) > 32'd99) begin
      wait_tens = 4'd9;
      wait_ones = 4'd9;
    end else begin
      wait_tens = 4'(32'(wait_q) / 32'd10);
      wait_ones = 4'(32'(wait_q) % 32'd10);
    end
  end

  assign count      = count_q;
  assign tellers    = tellers_q;
  assign wait_time  = wait_q;
  assign wait_valid = state_q == StDone;
  assign busy       = (state_q == StLoad) || (state_q == StDivide);
  assign no_teller  = no_teller_q;
  assign led_empty  = count_q == '0;
  assign led_full   = count_q == CNT_W'(DEPTH);
  assign err        = err_q;

endmodule

// File: tb/tb_queue_wait_controller.sv
// Bench for queue_wait_controller: table of press/switch steps with expected state, plus a
// scoreboard of expected wait results popped on every wait_valid pulse.
module tb_queue_wait_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       up_n = 1'b1;
  logic       down_n = 1'b1;
  logic [2:0] sw = 3'b000;
  logic [3:0] count;
  logic [1:0] tellers;
  logic [7:0] wait_time;
  logic [3:0] wait_tens, wait_ones;
  logic       wait_valid, busy, no_teller, led_empty, led_full, err;

  queue_wait_controller #(
    .DEPTH          (15),
    .N_TELLER       (3),
    .SERVICE        (3),
    .DEBOUNCE_CYCLES(4),
    .WAIT_W         (8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .up_n      (up_n),
    .down_n    (down_n),
    .sw        (sw),
    .count     (count),
    .tellers   (tellers),
    .wait_time (wait_time),
    .wait_tens (wait_tens),
    .wait_ones (wait_ones),
    .wait_valid(wait_valid),
    .busy      (busy),
    .no_teller (no_teller),
    .led_empty (led_empty),
    .led_full  (led_full),
    .err       (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int w;
    int nt;
  } exp_t;

  typedef struct {
    string      name;
    bit         is_sw;
    bit         up;
    bit         dn;
    logic [2:0] swv;
    int         reps;
    int         e_count;
    int         e_tel;
    int         e_errs;
    int         e_wait;
    int         e_nt;
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  int   err_seen = 0;
  int   m_count = 0;
  int   m_tel = 0;
  exp_t exp_q[$];
  vec_t vecs[11];

  function automatic int exp_wait(int c, int t);
    int w;
    if (t == 0) return 255;
    if (c == 0) return 0;
    w = (3 * c + t - 1) / t;
    return (w > 255) ? 255 : w;
  endfunction

  function automatic int tens_of(int w);
    return (w > 99) ? 9 : w / 10;
  endfunction

  function automatic int ones_of(int w);
    return (w > 99) ? 9 : w % 10;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic monitor();
    exp_t e;
    if (!reset) begin
      if (err) err_seen++;
      if (wait_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_wait_valid: got pulse with wait_time %0d expected none",
                   wait_time);
        end else begin
          e = exp_q.pop_front();
          check("sb_wait_time", int'(wait_time), e.w);
          check("sb_no_teller", int'(no_teller), e.nt);
          check("sb_tens", int'(wait_tens), tens_of(e.w));
          check("sb_ones", int'(wait_ones), ones_of(e.w));
        end
      end
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(negedge clk);
      monitor();
    end
  endtask

  task automatic model_update(input int c, input int t);
    exp_t e;
    if (c != m_count || t != m_tel) begin
      m_count = c;
      m_tel   = t;
      e.w     = exp_wait(c, t);
      e.nt    = (t == 0) ? 1 : 0;
      exp_q.push_back(e);
    end
  endtask

  task automatic press(input bit u, input bit d);
    int c;
    c      = m_count;
    up_n   = !u;
    down_n = !d;
    if (u && !d && c < 15) c++;
    else if (d && !u && c > 0) c--;
    model_update(c, m_tel);
    cycles(12);
    up_n   = 1'b1;
    down_n = 1'b1;
    cycles(12);
  endtask

  task automatic set_sw(input logic [2:0] v);
    sw = v;
    model_update(m_count, $countones(v));
    cycles(20);
  endtask

  initial begin
    int e0;
    int n;

    vecs[0]  = '{"sw011",    1'b1, 1'b0, 1'b0, 3'b011, 0,  0,  2, 0, 0,   0};
    vecs[1]  = '{"up5",      1'b0, 1'b1, 1'b0, 3'b011, 5,  5,  2, 0, 8,   0};
    vecs[2]  = '{"down2",    1'b0, 1'b0, 1'b1, 3'b011, 2,  3,  2, 0, 5,   0};
    vecs[3]  = '{"both",     1'b0, 1'b1, 1'b1, 3'b011, 1,  3,  2, 0, 5,   0};
    vecs[4]  = '{"down3",    1'b0, 1'b0, 1'b1, 3'b011, 3,  0,  2, 0, 0,   0};
    vecs[5]  = '{"down_at0", 1'b0, 1'b0, 1'b1, 3'b011, 1,  0,  2, 1, 0,   0};
    vecs[6]  = '{"sw001",    1'b1, 1'b0, 1'b0, 3'b001, 0,  0,  1, 0, 0,   0};
    vecs[7]  = '{"up16",     1'b0, 1'b1, 1'b0, 3'b001, 16, 15, 1, 1, 45,  0};
    vecs[8]  = '{"down11",   1'b0, 1'b0, 1'b1, 3'b001, 11, 4,  1, 0, 12,  0};
    vecs[9]  = '{"sw000",    1'b1, 1'b0, 1'b0, 3'b000, 0,  4,  0, 0, 255, 1};
    vecs[10] = '{"sw111",    1'b1, 1'b0, 1'b0, 3'b111, 0,  4,  3, 0, 4,   0};

    cycles(3);
    check("rst_count", int'(count), 0);
    check("rst_led_empty", int'(led_empty), 1);
    check("rst_led_full", int'(led_full), 0);
    check("rst_wait_time", int'(wait_time), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_tellers", int'(tellers), 0);
    check("rst_no_teller", int'(no_teller), 0);
    check("rst_wait_valid", int'(wait_valid), 0);
    check("rst_err", int'(err), 0);
    check("rst_tens", int'(wait_tens), 0);
    check("rst_ones", int'(wait_ones), 0);
    reset = 1'b0;
    cycles(5);

    for (int i = 0; i < 11; i++) begin
      e0 = err_seen;
      if (vecs[i].is_sw) set_sw(vecs[i].swv);
      else repeat (vecs[i].reps) press(vecs[i].up, vecs[i].dn);
      cycles(10);
      check({vecs[i].name, "_count"}, int'(count), vecs[i].e_count);
      check({vecs[i].name, "_tellers"}, int'(tellers), vecs[i].e_tel);
      check({vecs[i].name, "_errs"}, err_seen - e0, vecs[i].e_errs);
      check({vecs[i].name, "_led_full"}, int'(led_full), (vecs[i].e_count == 15) ? 1 : 0);
      check({vecs[i].name, "_led_empty"}, int'(led_empty), (vecs[i].e_count == 0) ? 1 : 0);
      check({vecs[i].name, "_wait_time"}, int'(wait_time), vecs[i].e_wait);
      check({vecs[i].name, "_no_teller"}, int'(no_teller), vecs[i].e_nt);
      check({vecs[i].name, "_tens"}, int'(wait_tens), tens_of(vecs[i].e_wait));
      check({vecs[i].name, "_ones"}, int'(wait_ones), ones_of(vecs[i].e_wait));
      check({vecs[i].name, "_sb_drain"}, exp_q.size(), 0);
    end

    // Three-cycle low glitch stays one sample short of the debounce window.
    e0   = err_seen;
    up_n = 1'b0;
    cycles(3);
    up_n = 1'b1;
    cycles(20);
    check("glitch_count", int'(count), 4);
    check("glitch_errs", err_seen - e0, 0);
    check("glitch_sb_drain", exp_q.size(), 0);

    // Reset while the divider is mid-computation.
    up_n = 1'b0;
    model_update(5, m_tel);
    n = 0;
    while (!busy && n < 40) begin
      cycles(1);
      n++;
    end
    check("div_started", int'(busy), 1);
    cycles(3);
    check("div_still_busy", int'(busy), 1);
    reset = 1'b1;
    up_n  = 1'b1;
    #1;
    check("midrst_busy", int'(busy), 0);
    check("midrst_wait_valid", int'(wait_valid), 0);
    check("midrst_count", int'(count), 0);
    check("midrst_wait_time", int'(wait_time), 0);
    exp_q.delete();
    m_count = 0;
    m_tel   = 0;
    cycles(3);
    reset = 1'b0;
    model_update(0, 3);
    cycles(25);
    check("postrst_tellers", int'(tellers), 3);
    check("postrst_wait_time", int'(wait_time), 0);
    check("postrst_count", int'(count), 0);
    check("postrst_sb_drain", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/queue_wait_controller.md
QUEUE_WAIT_CONTROLLER -- requirements
Module: queue_wait_controller

Interface
REQ-001 Parameters, one per line: name, default, meaning:
  DEPTH  15  maximum queue occupancy.
  N_TELLER  3  teller-enable switch count.
  SERVICE  3  service time per customer, in display units.
  DEBOUNCE_CYCLES  1000000  stable clk cycles required to accept a button level.
  WAIT_W  8  wait_time width.
REQ-002 Derived width: CNT_W = clog2(DEPTH+1); TW_W = clog2(N_TELLER+1).
REQ-003 Ports, one per line: name  direction  width  meaning:
  clk  in  1  single clock.
  reset  in  1  asynchronous, active-high reset.
  up_n  in  1  arrival button, active-low, raw/asynchronous.
  down_n  in  1  departure button, active-low, raw/asynchronous.
  sw  in  N_TELLER  teller-enable switches, raw/asynchronous.
  count  out  CNT_W  queue occupancy.
  tellers  out  TW_W  number of enabled tellers.
  wait_time  out  WAIT_W  computed wait.
  wait_tens  out  4  BCD tens digit of the displayed wait.
  wait_ones  out  4  BCD ones digit of the displayed wait.
  wait_valid  out  1  one-cycle pulse when wait_time updates.
  busy  out  1  divider running.
  no_teller  out  1  tellers==0.
  led_empty  out  1  count==0.
  led_full  out  1  count==DEPTH.
  err  out  1  one-cycle pulse on a rejected press.
REQ-004 Clock and reset: one clock, clk; reset is asynchronous and active-high, named reset.

Function
REQ-005 up_n, down_n and every sw bit SHALL each pass through a 2-FF synchroniser.
REQ-006 Each synchronised button SHALL update its debounced level only after DEBOUNCE_CYCLES consecutive identical samples; any toggle restarts the stability counter.
REQ-007 A press event SHALL be a one-cycle pulse on a debounced 1->0 transition; release SHALL produce no event.
REQ-008 Counter rules on a press event:
  - up only, count<DEPTH: count+1.
  - down only, count>0: count-1.
  - up only at count==DEPTH: count held, err pulse.
  - down only at count==0: count held, err pulse.
  - up and down in the same cycle: count held, no err.
REQ-009 led_empty and led_full SHALL be decoded directly from the count register, with no extra latency.
REQ-010 tellers SHALL be the registered popcount of the synchronised sw.
REQ-011 Divider FSM states and transitions:
  - IDLE -> LOAD when {count, tellers} differs from the last computed operands.
  - LOAD -> DIVIDE.
  - DIVIDE lasts WAIT_W cycles, restoring division, one quotient bit per cycle.
  - DIVIDE -> DONE -> IDLE.
REQ-012 The result SHALL be wait_time = ceil(SERVICE*count / tellers), computed with the dividend widened to avoid overflow and saturated to 2^WAIT_W-1.
REQ-013 LOAD with tellers==0 SHALL take LOAD -> DONE and set wait_time=all ones and no_teller=1; no_teller SHALL clear on the next completed computation with tellers>0.
REQ-014 LOAD with count==0 and tellers>0 SHALL take LOAD -> DONE and set wait_time=0.
REQ-015 busy SHALL be high in LOAD and DIVIDE.
REQ-016 wait_time and wait_valid SHALL update in DONE; latency from operand change to wait_valid is WAIT_W+2 cycles for a division and 2 cycles for a short-cut.
REQ-017 Operand changes during busy SHALL NOT abort the computation; after DONE the FSM SHALL re-enter LOAD if the operands differ from those just used.
REQ-018 BCD digits: wait_tens/wait_ones = wait_time/10 and wait_time%10, combinational; wait_time>99 SHALL display 9,9.

Reset
REQ-019 On reset assertion, independent of clk:
  - count=0, tellers=0, wait_time=0, digits 0,0.
  - led_empty=1, led_full=0, no_teller=0.
  - wait_valid=0, busy=0, err=0.
  - FSM=IDLE, debounced levels=1, synchronisers=1.
REQ-020 Reset mid-division SHALL abandon the computation with no wait_valid pulse; after release, the first computation SHALL start within 3 cycles if the operands are nonzero.

Verification (DEBOUNCE_CYCLES=4 on bench, other parameters at default)
REQ-021 Reset -> count=0, led_empty=1, wait_time=0, busy=0.
REQ-022 sw=011, five clean up presses -> count=5, tellers=2, wait_time=8, digits 0,8, one wait_valid per settled computation.
REQ-023 sw=001, sixteen up presses -> count=15, led_full=1, err pulses once on the 16th press, wait_time=45, digits 4,5.
REQ-024 up_n low-glitch for 3 cycles -> no count change, no err.
REQ-025 count=4, sw=000 -> wait_time=255, no_teller=1, digits 9,9; then sw=111 -> wait_time=4, no_teller=0.
REQ-026 Two cases:
  - up and down pressed in the same cycle at count=3 -> count=3, no err.
  - reset asserted during DIVIDE -> busy=0 immediately, no wait_valid pulse.
